// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 SEQ sequencer slice.
//   - icode constants (I_HALT .. I_POP)
//   - processor status codes (stat_e)
//   - stage-state encoding for the sequencer FSM (stage_e)
// No ports; imported by seq_pc_sel and seq_stage_ctrl.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    // S_STEP_WAIT is only reachable when single-step support is built in.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_F         = 4'd1,
        S_D         = 4'd2,
        S_E         = 4'd3,
        S_M         = 4'd4,
        S_W         = 4'd5,
        S_PCU       = 4'd6,
        S_HALT      = 4'd7,
        S_STEP_WAIT = 4'd8
    } stage_e;

endpackage

// File: rtl/seq_pc_sel.sv
// seq_pc_sel: combinational next-PC selector.
// Ports:
//   icode  in  4   latched instruction code
//   cnd    in  1   latched branch condition
//   valC   in  64  latched constant word (call / jump target)
//   valP   in  64  latched fall-through PC
//   valM   in  64  latched memory read data (return address)
//   new_pc out 64  PC of the next instruction
module seq_pc_sel
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] new_pc
);

    always_comb begin
        new_pc = valP;
        case (icode)
            I_CALL:  new_pc = valC;
            I_JXX:   if (cnd) new_pc = valC;
            I_RET:   new_pc = valM;
            default: new_pc = valP;
        endcase
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle sequencer for the Y86-64 SEQ processor.
// Walks one instruction through F, D, E, M, W and PC-update, one stage per
// cycle, owns the architectural PC and Stat, and stops on halt or a fault.
//
// Optional build macro: SEQ_SINGLE_STEP_EN adds a `step` input; after each
// PC update the machine parks in S_STEP_WAIT until step (or start).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   step            (SEQ_SINGLE_STEP_EN only) advance one instruction
//   start/start_pc  begin execution at start_pc from IDLE/HALT/STEP_WAIT
//   icode, valC, valP, imem_error, instr_valid, hlt   fetch results (F cycle)
//   cnd             condition from execute (E cycle)
//   valM, dmem_error  memory results (M cycle)
//   pc              architectural PC, stable for a whole instruction
//   en_f..en_w      one-hot stage enables (Moore, decoded from state flop)
//   stat            1=AOK 2=HLT 3=ADR 4=INS
//   busy            high in any stage state F..PCU
//   instr_count     retired-instruction count, wraps
//   state_dbg       current FSM state encoding (stage_e)
//
// Handshake: start/step are single-cycle pulses sampled on the rising edge;
// they are acted on only when busy is low, and rst wins over both.
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic [63:0]      start_pc,
    input  logic [3:0]       icode,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             hlt,
    input  logic             cnd,
    input  logic [63:0]      valM,
    input  logic             dmem_error,
    output logic [63:0]      pc,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    stage_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    stat_e            stat_q, stat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-instruction values captured in the stage where they are valid.
    logic [3:0]       icode_q, icode_d;
    logic [63:0]      valc_q, valc_d;
    logic [63:0]      valp_q, valp_d;
    logic             cnd_q, cnd_d;
    logic [63:0]      valm_q, valm_d;

    logic [63:0]      new_pc;

    seq_pc_sel u_pc_sel (
        .icode  (icode_q),
        .cnd    (cnd_q),
        .valC   (valc_q),
        .valP   (valp_q),
        .valM   (valm_q),
        .new_pc (new_pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
            icode_q <= '0;
            valc_q  <= '0;
            valp_q  <= '0;
            cnd_q   <= 1'b0;
            valm_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            icode_q <= icode_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            cnd_q   <= cnd_d;
            valm_q  <= valm_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        icode_d = icode_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        cnd_d   = cnd_q;
        valm_d  = valm_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_F;
                    pc_d    = start_pc;
                    stat_d  = STAT_AOK;
                end
            end
            S_F: begin
                icode_d = icode;
                valc_d  = valC;
                valp_d  = valP;
                // Fault priority: address fault, then bad instruction, then halt.
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALT;
                end else if (hlt) begin
                    stat_d  = STAT_HLT;
                    state_d = S_HALT;
                end else begin
                    state_d = S_D;
                end
            end
            S_D: state_d = S_E;
            S_E: begin
                cnd_d   = cnd;
                state_d = S_M;
            end
            S_M: begin
                valm_d = valM;
                if (dmem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else begin
                    state_d = S_W;
                end
            end
            S_W: state_d = S_PCU;
            S_PCU: begin
                pc_d  = new_pc;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
                state_d = S_STEP_WAIT;
`else
                state_d = S_F;
`endif
            end
            S_STEP_WAIT: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (start) begin
                    state_d = S_F;
                    pc_d    = start_pc;
                    stat_d  = STAT_AOK;
                end else if (step) begin
                    state_d = S_F;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state flop
    always_comb begin
        en_f = (state_q == S_F);
        en_d = (state_q == S_D);
        en_e = (state_q == S_E);
        en_m = (state_q == S_M);
        en_w = (state_q == S_W);
        busy = (state_q == S_F) || (state_q == S_D) || (state_q == S_E) ||
               (state_q == S_M) || (state_q == S_W) || (state_q == S_PCU);
    end

    assign pc          = pc_q;
    assign stat        = stat_q;
    assign instr_count = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl. Reference model works per
// instruction: from the instruction's fields it predicts the stage trace,
// the resulting PC, Stat and retired count.
module tb_seq_stage_ctrl;

    localparam logic [63:0] RST_PC = 64'h0000_0000_0000_0abc;
    localparam int          CW     = 4;

    logic          clk;
    logic          rst;
`ifdef SEQ_SINGLE_STEP_EN
    logic          step;
`endif
    logic          start;
    logic [63:0]   start_pc;
    logic [3:0]    icode;
    logic [63:0]   valC;
    logic [63:0]   valP;
    logic          imem_error;
    logic          instr_valid;
    logic          hlt;
    logic          cnd;
    logic [63:0]   valM;
    logic          dmem_error;
    logic [63:0]   pc;
    logic          en_f, en_d, en_e, en_m, en_w;
    logic [2:0]    stat;
    logic          busy;
    logic [CW-1:0] instr_count;
    logic [3:0]    state_dbg;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0]   m_pc;
    logic [2:0]    m_stat;
    logic [CW-1:0] m_cnt;

    // Expected per-cycle enable vectors {f,d,e,m,w}
    logic [4:0] exp_q[$];

    seq_stage_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .start       (start),
        .start_pc    (start_pc),
        .icode       (icode),
        .valC        (valC),
        .valP        (valP),
        .imem_error  (imem_error),
        .instr_valid (instr_valid),
        .hlt         (hlt),
        .cnd         (cnd),
        .valM        (valM),
        .dmem_error  (dmem_error),
        .pc          (pc),
        .en_f        (en_f),
        .en_d        (en_d),
        .en_e        (en_e),
        .en_m        (en_m),
        .en_w        (en_w),
        .stat        (stat),
        .busy        (busy),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_garbage();
        icode       = 4'($urandom);
        valC        = {$urandom, $urandom};
        valP        = {$urandom, $urandom};
        imem_error  = 1'($urandom_range(0, 1));
        instr_valid = 1'($urandom_range(0, 1));
        hlt         = 1'($urandom_range(0, 1));
        cnd         = 1'($urandom_range(0, 1));
        valM        = {$urandom, $urandom};
        dmem_error  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step  = 1'b0;
`endif
        drive_garbage();
        tick();
        tick();
        rst    = 1'b0;
        m_pc   = RST_PC;
        m_stat = 3'd1;
        m_cnt  = '0;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [2:0] exp_stat);
        checks++;
        if ({en_f, en_d, en_e, en_m, en_w} !== 5'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s enables/busy: got en=%b busy=%b want en=00000 busy=0",
                     tag, {en_f, en_d, en_e, en_m, en_w}, busy);
        end
        checks++;
        if (pc !== m_pc || stat !== exp_stat) begin
            errors++;
            $display("FAIL %s pc/stat: got pc=%h stat=%0d want pc=%h stat=%0d",
                     tag, pc, stat, m_pc, exp_stat);
        end
    endtask

    // Pulse start from a non-busy state; machine is in F afterwards.
    task automatic do_start(input logic [63:0] spc);
        drive_garbage();
        start    = 1'b1;
        start_pc = spc;
        tick();
        start  = 1'b0;
        m_pc   = spc;
        m_stat = 3'd1;
        checks++;
        if (pc !== spc || stat !== 3'd1 || {en_f, en_d, en_e, en_m, en_w} !== 5'b10000 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL start: got pc=%h stat=%0d en=%b busy=%b want pc=%h stat=1 en=10000 busy=1",
                     pc, stat, {en_f, en_d, en_e, en_m, en_w}, busy, spc);
        end
    endtask

    function automatic logic [63:0] ref_next_pc(input logic [3:0] ic, input logic c,
                                                input logic [63:0] vc, input logic [63:0] vp,
                                                input logic [63:0] vm);
        if (ic == 4'h8) return vc;
        if (ic == 4'h7 && c) return vc;
        if (ic == 4'h9) return vm;
        return vp;
    endfunction

    // Driver + scoreboard for one instruction starting in the F cycle.
    // Stage inputs carry real values only in their own cycle; random data
    // elsewhere. rnd_start throws ignored start pulses at the busy machine.
    task automatic exec_instr(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                              input logic c, input logic [63:0] vm,
                              input logic ie, input logic iv, input logic h, input logic de,
                              input logic rnd_start, input string tag);
        logic [4:0]  exp_en;
        logic        fetch_fault;
        logic [63:0] old_pc;
        fetch_fault = ie || !iv || h;
        old_pc      = m_pc;
        exp_q.push_back(5'b10000);
        if (!fetch_fault) begin
            exp_q.push_back(5'b01000);
            exp_q.push_back(5'b00100);
            exp_q.push_back(5'b00010);
            if (!de) begin
                exp_q.push_back(5'b00001);
                exp_q.push_back(5'b00000);
            end
        end
        while (exp_q.size() > 0) begin
            exp_en = exp_q.pop_front();
            checks++;
            if ({en_f, en_d, en_e, en_m, en_w} !== exp_en || pc !== old_pc || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s stage: got en=%b pc=%h busy=%b want en=%b pc=%h busy=1",
                         tag, {en_f, en_d, en_e, en_m, en_w}, pc, busy, exp_en, old_pc);
            end
            drive_garbage();
            if (exp_en == 5'b10000) begin
                icode = ic; valC = vc; valP = vp;
                imem_error = ie; instr_valid = iv; hlt = h;
            end
            if (exp_en == 5'b00100) cnd = c;
            if (exp_en == 5'b00010) begin
                valM = vm; dmem_error = de;
            end
            start    = rnd_start ? 1'($urandom_range(0, 2) == 0) : 1'b0;
            start_pc = {$urandom, $urandom};
            tick();
        end
        start = 1'b0;
        if (ie)       m_stat = 3'd3;
        else if (!iv) m_stat = 3'd4;
        else if (h)   m_stat = 3'd2;
        else if (de)  m_stat = 3'd3;
        else begin
            m_pc  = ref_next_pc(ic, c, vc, vp, vm);
            m_cnt = m_cnt + 1'b1;
        end
        if (fetch_fault || de) begin
            check_idle_outputs({tag, " halt"}, m_stat);
        end else begin
`ifdef SEQ_SINGLE_STEP_EN
            check_idle_outputs({tag, " stepwait"}, 3'd1);
            step = 1'b1;
            tick();
            step = 1'b0;
`endif
            checks++;
            if (pc !== m_pc || stat !== 3'd1 || {en_f, en_d, en_e, en_m, en_w} !== 5'b10000) begin
                errors++;
                $display("FAIL %s retire: got pc=%h stat=%0d en=%b want pc=%h stat=1 en=10000",
                         tag, pc, stat, {en_f, en_d, en_e, en_m, en_w}, m_pc);
            end
        end
        checks++;
        if (instr_count !== m_cnt) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", tag, instr_count, m_cnt);
        end
    endtask

    // Stop a running machine with a halt instruction.
    task automatic halt_machine();
        exec_instr(4'h0, 64'h0, m_pc + 64'd1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "halt");
    endtask

    task automatic test_reset();
        do_reset();
        check_idle_outputs("reset", 3'd1);
        checks++;
        if (instr_count !== '0) begin
            errors++;
            $display("FAIL reset count: got %0d want 0", instr_count);
        end
        // Idle must ignore stage inputs without start.
        for (int i = 0; i < 3; i++) begin
            drive_garbage();
            tick();
        end
        check_idle_outputs("idle hold", 3'd1);
    endtask

    task automatic test_nop();
        do_reset();
        do_start(64'd32);
        exec_instr(4'h1, 64'hdead, 64'd33, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "nop");
        halt_machine();
    endtask

    task automatic test_jxx();
        do_start(64'd40);
        exec_instr(4'h7, 64'h100, 64'd49, 1'b1, 64'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "jxx taken");
        halt_machine();
        do_start(64'd40);
        exec_instr(4'h7, 64'h100, 64'd49, 1'b0, 64'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "jxx not taken");
        halt_machine();
    endtask

    task automatic test_call_ret();
        do_reset();
        do_start(64'h80);
        exec_instr(4'h8, 64'h200, 64'h89, 1'b0, 64'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "call");
        exec_instr(4'h9, 64'h999, 64'h201, 1'b0, 64'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "ret");
        halt_machine();
    endtask

    task automatic test_fetch_faults();
        do_start(64'd64);
        exec_instr(4'h0, 64'h0, 64'd65, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "fault hlt");
        for (int i = 0; i < 3; i++) begin
            drive_garbage();
            tick();
        end
        check_idle_outputs("halt hold", 3'd2);
        do_start(64'd72);
        exec_instr(4'hf, 64'h0, 64'd73, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fault ins");
        do_start(64'd1024);
        exec_instr(4'h1, 64'h0, 64'd1025, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "fault adr");
    endtask

    task automatic test_dmem_fault();
        do_start(64'h300);
        exec_instr(4'h5, 64'h40, 64'h30a, 1'b0, 64'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "dmem fault");
    endtask

    task automatic test_rst_mid();
        do_start(64'h500);
        drive_garbage();
        icode = 4'h6; imem_error = 1'b0; instr_valid = 1'b1; hlt = 1'b0;
        tick();
        tick();
        checks++;
        if (en_e !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid reach E: got en_e=%b want 1", en_e);
        end
        do_reset();
        check_idle_outputs("rst mid", 3'd1);
        for (int i = 0; i < 4; i++) begin
            drive_garbage();
            tick();
        end
        check_idle_outputs("rst mid hold", 3'd1);
        // rst wins over start in the same cycle
        start = 1'b1; start_pc = 64'h777; rst = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        check_idle_outputs("rst vs start", 3'd1);
        do_start(64'h600);
        halt_machine();
        do_start(64'h700);
        halt_machine();
    endtask

    task automatic test_random();
        logic [3:0]  ic;
        logic [63:0] vp;
        logic        ie, iv, h, de;
        int          f;
        do_reset();
        do_start({$urandom, $urandom});
        for (int n = 0; n < 60; n++) begin
            ic = 4'($urandom_range(0, 11));
            vp = m_pc + 64'($urandom_range(1, 10));
            f  = $urandom_range(0, 15);
            ie = (f == 0);
            iv = (f != 1);
            h  = (f == 2);
            de = (f == 3);
            exec_instr(ic, {$urandom, $urandom}, vp, 1'($urandom_range(0, 1)),
                       {$urandom, $urandom}, ie, iv, h, de, 1'b1, "random");
            if (ie || !iv || h || de) do_start({$urandom, $urandom});
        end
        halt_machine();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_pc = '0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        drive_garbage();
        test_reset();
        test_nop();
        test_jxx();
        test_call_ret();
        test_fetch_faults();
        test_dmem_fault();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
- Multi-cycle sequencer for the Y86-64 SEQ processor.
- Steps one instruction through Fetch, Decode, Execute, Memory, Writeback and PC-update, pulsing one stage enable per cycle.
- Owns the architectural PC register and the processor status (Stat).
- Selects the next PC (valP/valC/valM) and stops the machine on halt or on any fault.

Parameters:
- RESET_PC, 64'd0: PC loaded at reset.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; starts execution at start_pc when idle or halted
- start_pc  input  64  PC loaded on start
- icode  input  4  from fetch
- valC  input  64  from fetch
- valP  input  64  from fetch
- imem_error  input  1  from fetch
- instr_valid  input  1  from fetch
- hlt  input  1  from fetch
- cnd  input  1  branch/cmov condition from execute, valid in E cycle
- valM  input  64  memory read data, valid in M cycle
- dmem_error  input  1  data-memory fault, valid in M cycle
- pc  output  64  current PC, held stable across all stages of an instruction
- en_f  output  1  fetch enable
- en_d  output  1  decode enable
- en_e  output  1  execute enable
- en_m  output  1  memory enable
- en_w  output  1  writeback enable
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  output  1  high in any stage state
- instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, stat=AOK, all en_*=0, busy=0, instr_count=0. Reset mid-instruction aborts it; no further enables are issued.
- States: IDLE, F, D, E, M, W, PCU, HALT. Enables are registered Moore outputs: en_f=1 exactly while state==F, and likewise for D/E/M/W. PCU has no enable.
- IDLE: start goes to F, loads pc=start_pc, sets stat=AOK.
- Nominal path: F→D→E→M→W→PCU→F, 6 cycles per instruction.
- F: latch icode, valC, valP. Fault priority:
  - imem_error: stat=ADR, go to HALT.
  - else !instr_valid: stat=INS, go to HALT.
  - else hlt: stat=HLT, go to HALT.
  - else go to D.
  - pc is unchanged on any fault.
- E: latch cnd.
- M: latch valM. If dmem_error: stat=ADR, go to HALT, skip W and PCU, pc unchanged.
- PCU: pc ← new_pc and instr_count increments (wraps at 2^CNT_W). new_pc:
  - call (8): valC
  - jXX (7) with cnd=1: valC
  - ret (9): latched valM
  - otherwise: latched valP
- HALT: stat and pc hold; busy=0. start re-enters F with pc=start_pc and stat=AOK. Other inputs are ignored.
- start while busy is ignored. rst has priority over start in the same cycle.
- Halted and faulting instructions are not counted.
- All PC arithmetic is 64-bit; no wrap checks on PC.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: adds input step (1 bit). After PCU the FSM goes to IDLE-like STEP_WAIT (busy=0, stat=AOK) instead of F, and proceeds to F on a step pulse. start from STEP_WAIT restarts at start_pc.
- Undefined: no step port; PCU goes directly to F.

Decomposition:
- Shared package y86_pkg:
  - icode constants: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B
  - stat codes: AOK, HLT, ADR, INS
  - stage-state enum
- One combinational sub-module, seq_pc_sel: inputs icode, cnd, valC, valP, valM; output new_pc.

Test Plan:
- Reset then start with start_pc=32, nop (valP=33): en_f..en_w pulse on cycles 1–5, pc=33 after cycle 6, instr_count=1.
- jXX at pc=40, valC=0x100, valP=49:
  - cnd=1: pc=0x100.
  - cnd=0: pc=49.
- call (valC=0x200) → pc=0x200; then ret with valM=0x55 → pc=0x55; instr_count=2.
- Fetch faults:
  - hlt=1 at pc=64: stat=2, pc stays 64, no en_d.
  - instr_valid=0: stat=4.
  - imem_error with PC=1024: stat=3.
- dmem_error=1 in M: stat=3, en_w never asserted, pc unchanged, count unchanged.
- rst asserted during E: next cycle IDLE, pc=RESET_PC, all enables 0. Then start from HALT resumes with stat=AOK.
